// File: rtl/apb_sram_bridge.sv
// APB4 slave to single-port SRAM (port 0) controller.
// Each legal APB transfer becomes exactly one single-cycle SRAM command; reads
// add wait states to cover the SRAM read latency, illegal addresses complete
// immediately with pslverr and never touch the SRAM.
module apb_sram_bridge #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter int          MEM_WORDS = 256,
   parameter int          ADDR_W    = 8,
   parameter int          RD_LAT    = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              psel,
   input  logic              penable,
   input  logic              pwrite,
   input  logic [31:0]       paddr,
   input  logic [31:0]       pwdata,
   input  logic [3:0]        pstrb,
   output logic [31:0]       prdata,
   output logic              pready,
   output logic              pslverr,
   output logic              sram_csb0,
   output logic              sram_web0,
   output logic [3:0]        sram_wmask0,
   output logic [ADDR_W-1:0] sram_addr0,
   output logic [31:0]       sram_din0,
   input  logic [31:0]       sram_dout0
);

   typedef enum logic [1:0] {IDLE, CMD, WAIT, RESP} state_t;

   localparam int              CNT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(RD_LAT - 1);
   localparam logic [32:0]     MEM_BYTES = 33'(MEM_WORDS) * 33'd4;

   state_t           state, state_next;
   logic [CNT_W-1:0] wait_cnt;
   logic             wr_q;
   logic             setup;
   logic             addr_err;
   logic             last_wait;
   logic [31:0]      offset;

   // Address decode happens on the live setup-phase inputs so the SRAM command
   // can be registered on the same edge that leaves IDLE.
   assign setup     = psel & ~penable;
   assign offset    = paddr - BASE_ADDR;
   assign addr_err  = (paddr[1:0] != 2'b00) || (paddr < BASE_ADDR) ||
                      ({1'b0, offset} >= MEM_BYTES);
   assign last_wait = (wait_cnt == WAIT_LAST);

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of process ordering.
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic; a dropped psel before pready abandons the transfer.
   always_comb begin
      // NOTE: default first so no path leaves state_next unassigned (no latch).
      state_next = state;
      unique case (state)
         IDLE: if (setup) state_next = addr_err ? RESP : CMD;
         CMD: begin
            if (!psel)     state_next = IDLE;
            else if (wr_q) state_next = RESP;
            else           state_next = WAIT;
         end
         WAIT: begin
            if (!psel)          state_next = IDLE;
            else if (last_wait) state_next = RESP;
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Registered SRAM command, APB response and read-latency counter.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sram_csb0   <= 1'b1;
         sram_web0   <= 1'b1;
         sram_wmask0 <= 4'b0000;
         sram_addr0  <= '0;
         sram_din0   <= '0;
         prdata      <= '0;
         pready      <= 1'b0;
         pslverr     <= 1'b0;
         wr_q        <= 1'b0;
         wait_cnt    <= '0;
      end else begin
         // Command strobes are single-cycle: idle unless entering CMD below.
         sram_csb0 <= 1'b1;
         sram_web0 <= 1'b1;
         pready    <= (state_next == RESP);
         pslverr   <= 1'b0;

         if (state == IDLE && setup) begin
            wr_q <= pwrite;
            if (addr_err) begin
               pslverr <= 1'b1;
               prdata  <= '0;
            end else begin
               sram_csb0   <= 1'b0;
               sram_web0   <= ~pwrite;
               sram_addr0  <= offset[ADDR_W+1:2];
               sram_wmask0 <= pwrite ? pstrb : 4'b0000;
               if (pwrite) sram_din0 <= pwdata;
            end
         end

         if (state == WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
         else               wait_cnt <= '0;

         if (state == WAIT && psel && last_wait) prdata <= sram_dout0;
      end
   end

endmodule
